awgn_sweep_ctrl: RTL
====================

# awgn_sweep_ctrl

Sequencer for the AWGNGenerator noise source. Steps the generator through a programmed table of SNR points and holds each point for a fixed number of valid noise samples. After each SNR change it discards the generator's pipeline-flush samples, then forwards tagged, qualified noise samples to the channel model. It sits between the test/config master and the AWGNGenerator instance, and owns that instance's `snrdB`, `clk_enable` and `reset` pins.

## Interface
Parameters:
- `MAX_POINTS`, 8 — SNR table depth; power of two.
- `CNT_W`, 16 — width of the samples-per-point counter.
- `SETTLE_CYCLES`, 8 — enabled cycles discarded after each SNR change; must be ≥1.

Ports:
- `clk`  in  1  — single clock.
- `reset`  in  1  — asynchronous, active-low.
- `cfg_we`  in  1  — table write strobe.
- `cfg_addr`  in  log2(MAX_POINTS)  — table index.
- `cfg_snrdB`  in  16  — sfix16_En9 SNR value.
- `num_points`  in  log2(MAX_POINTS)+1  — points to sweep.
- `samples_per_point`  in  CNT_W  — valid samples per point; 0 is treated as 1.
- `start`  in  1  — one-cycle sweep request.
- `abort`  in  1  — terminate the sweep.
- `busy`  out  1  — high while a sweep is running.
- `done`  out  1  — one-cycle pulse at sweep end or abort.
- `gen_reset`  out  1  — active-high reset to the generator.
- `gen_ce`  out  1  — generator `clk_enable`.
- `gen_snrdB`  out  16  — generator `snrdB`.
- `gen_valid`  in  1  — generator `valid`.
- `gen_re`, `gen_im`  in  38 each  — sfix38_En29 noise.
- `out_valid`  out  1  — qualified sample.
- `out_re`, `out_im`  out  38 each  — registered copy of the noise sample.
- `out_point`  out  log2(MAX_POINTS)  — table index of the current sample.

## Operation
- The table is a register array, written when `cfg_we`=1 and state is IDLE. Writes in any other state are ignored.
- `num_points` and `samples_per_point` are latched on an accepted `start`.
- States:
  - **IDLE**
    - `start`=1 with latched `num_points`=0 → DONE.
    - `start`=1 with `num_points`>0 → RESET_GEN.
  - **RESET_GEN** (1 cycle)
    - `gen_reset`=1, point index = 0, `gen_snrdB` = table[0].
    - → SETTLE.
  - **SETTLE**
    - `gen_ce`=1; the settle counter counts `SETTLE_CYCLES`.
    - `gen_valid` is ignored.
    - At terminal count → RUN.
  - **RUN**
    - `gen_ce`=1; each `gen_valid` produces an output sample and increments the sample counter.
    - On the valid that makes count = `samples_per_point`: if point = `num_points`−1 → DONE; otherwise point+1, `gen_snrdB` = table[point+1], counter cleared → SETTLE.
  - **DONE** (1 cycle)
    - `done`=1, `gen_ce`=0.
    - → IDLE.
- `abort` in RESET_GEN, SETTLE or RUN → DONE next cycle. It overrides the sample completion event in the same cycle, and the sample in that cycle is not forwarded.
- `start` while not IDLE is ignored.
- `num_points` > `MAX_POINTS` is clamped to `MAX_POINTS`.
- `busy` = state ∉ {IDLE, DONE}.

## Timing
- Reset values:
  - `busy`, `done`, `gen_ce`, `out_valid` = 0.
  - `gen_reset` = 1 (the generator is held in reset until the first sweep).
  - `gen_snrdB` = 0, `out_re`/`out_im` = 0, `out_point` = 0.
  - The table resets to all 0.
- `gen_reset` deasserts in IDLE after the first clock following reset release. In RESET_GEN it asserts for exactly one cycle.
- Start latency: `start` at cycle 0 → `gen_reset` high cycle 1 → `gen_ce` high from cycle 2.
- `gen_snrdB` changes only on entry to RESET_GEN or on a point advance; it is held stable for the whole point.
- Output latency: `out_*` is registered, 1 cycle after the qualifying `gen_valid`. `out_point` is the index in effect when that sample was accepted.
- The counter wraps at exactly `samples_per_point`, never `samples_per_point`+1. Each point yields exactly `samples_per_point` `out_valid` pulses.
- Asynchronous reset mid-sweep returns immediately to the reset values and does not pulse `done`.

## Structure
- Shared package `awgn_pkg`:
  - `SNR_W`=16, `SNR_FRAC`=9, `AWGN_W`=38, `AWGN_FRAC`=29.
  - State encoding constants.
- One natural sub-module, `snr_table_regs`: the MAX_POINTS×16 register file with write port and asynchronous read.
- The FSM and counters stay in the top module.
- The AWGNGenerator is instantiated by the parent, not inside this block.

## Test plan
- Reset with `start` held low → `gen_reset`=1 then 0 in IDLE; all other outputs at reset values; no `out_valid`.
- Table {0x0000, 0x0A00, 0x1400}, `num_points`=3, `samples_per_point`=4, `gen_valid` constant 1 → `gen_snrdB` steps through the three values.
  - 12 `out_valid` pulses total, 4 per `out_point` 0/1/2.
  - `SETTLE_CYCLES` gaps between points.
  - `done` pulses once.
- `gen_valid` toggling every 3rd cycle, `samples_per_point`=5 → exactly 5 outputs per point; sample data matches the generator input delayed by 1 cycle.
- `abort` asserted in RUN on the same cycle as the 4th valid of 4 → no output for that sample, `done` next cycle, `busy`=0, point not advanced.
- `num_points`=0 → `done` 1 cycle after `start`; `gen_ce` never asserted.
- `cfg_we` to address 1 with 0x7FFF during RUN → table unchanged; a second sweep still uses the old value. `start` during RUN is ignored (no restart).

Source files
------------

// File: rtl/awgn_pkg.sv
// Shared widths and sweep state encoding for the AWGN sweep controller.
package awgn_pkg;

  localparam int unsigned SNR_W     = 16;
  localparam int unsigned SNR_FRAC  = 9;
  localparam int unsigned AWGN_W    = 38;
  localparam int unsigned AWGN_FRAC = 29;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StResetGen = 3'd1,
    StSettle   = 3'd2,
    StRun      = 3'd3,
    StDone     = 3'd4
  } sweep_state_e;

endpackage

// File: rtl/snr_table_regs.sv
// SNR point table: register file with one synchronous write port and an
// asynchronous read port.
module snr_table_regs
  import awgn_pkg::*;
#(
  parameter int unsigned MAX_POINTS = 8,
  parameter int unsigned ADDR_W     = $clog2(MAX_POINTS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [SNR_W-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [SNR_W-1:0]  rdata
);

  logic [SNR_W-1:0] mem_q [MAX_POINTS];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < MAX_POINTS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/awgn_sweep_ctrl.sv
// Sweeps the AWGN generator through a table of SNR points, discards settle
// samples after each SNR change and forwards tagged noise samples.
module awgn_sweep_ctrl
  import awgn_pkg::*;
#(
  parameter int unsigned MAX_POINTS    = 8,
  parameter int unsigned CNT_W         = 16,
  parameter int unsigned SETTLE_CYCLES = 8,
  localparam int unsigned PtW          = $clog2(MAX_POINTS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_we,
  input  logic [PtW-1:0]    cfg_addr,
  input  logic [SNR_W-1:0]  cfg_snrdB,
  input  logic [PtW:0]      num_points,
  input  logic [CNT_W-1:0]  samples_per_point,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              gen_reset,
  output logic              gen_ce,
  output logic [SNR_W-1:0]  gen_snrdB,
  input  logic              gen_valid,
  input  logic [AWGN_W-1:0] gen_re,
  input  logic [AWGN_W-1:0] gen_im,
  output logic              out_valid,
  output logic [AWGN_W-1:0] out_re,
  output logic [AWGN_W-1:0] out_im,
  output logic [PtW-1:0]    out_point
);

  localparam int unsigned   SetW    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [PtW:0]  MaxPts  = (PtW + 1)'(MAX_POINTS);
  localparam logic [SetW-1:0] SetLast = SetW'(SETTLE_CYCLES - 1);

  sweep_state_e     state_q, state_d;
  logic [PtW-1:0]   point_q, point_d;
  logic [CNT_W-1:0] smp_cnt_q, smp_cnt_d;
  logic [SetW-1:0]  settle_cnt_q, settle_cnt_d;
  logic [PtW:0]     num_points_q, num_points_d;
  logic [CNT_W-1:0] spp_q, spp_d;
  logic [SNR_W-1:0] snr_q, snr_d;
  logic             gen_reset_q;

  logic             out_valid_q;
  logic [AWGN_W-1:0] out_re_q, out_im_q;
  logic [PtW-1:0]   out_point_q;

  logic             tbl_we;
  logic [PtW-1:0]   tbl_raddr;
  logic [SNR_W-1:0] tbl_rdata;
  logic [PtW:0]     num_points_clamped;
  logic             last_smp, last_point, accept;

  assign tbl_we = cfg_we && (state_q == StIdle);
  // Index 0 is read while idle (sweep start), the next point while running.
  assign tbl_raddr = (state_q == StRun) ? point_q + PtW'(1) : '0;

  snr_table_regs #(
    .MAX_POINTS (MAX_POINTS),
    .ADDR_W     (PtW)
  ) u_snr_table (
    .clk   (clk),
    .reset (reset),
    .we    (tbl_we),
    .waddr (cfg_addr),
    .wdata (cfg_snrdB),
    .raddr (tbl_raddr),
    .rdata (tbl_rdata)
  );

  assign num_points_clamped = (num_points > MaxPts) ? MaxPts : num_points;
  assign last_smp   = (smp_cnt_q == spp_q - CNT_W'(1));
  assign last_point = ({1'b0, point_q} == num_points_q - (PtW + 1)'(1));

  always_comb begin
    state_d      = state_q;
    point_d      = point_q;
    smp_cnt_d    = smp_cnt_q;
    settle_cnt_d = settle_cnt_q;
    num_points_d = num_points_q;
    spp_d        = spp_q;
    snr_d        = snr_q;
    accept       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          num_points_d = num_points_clamped;
          spp_d        = (samples_per_point == '0) ? CNT_W'(1) : samples_per_point;
          point_d      = '0;
          smp_cnt_d    = '0;
          settle_cnt_d = '0;
          if (num_points_clamped == '0) begin
            state_d = StDone;
          end else begin
            state_d = StResetGen;
            snr_d   = tbl_rdata;
          end
        end
      end
      StResetGen: begin
        state_d = abort ? StDone : StSettle;
      end
      StSettle: begin
        if (abort) begin
          state_d = StDone;
        end else if (settle_cnt_q == SetLast) begin
          settle_cnt_d = '0;
          state_d      = StRun;
        end else begin
          settle_cnt_d = settle_cnt_q + SetW'(1);
        end
      end
      StRun: begin
        if (abort) begin
          state_d = StDone;
        end else if (gen_valid) begin
          accept = 1'b1;
          if (last_smp) begin
            smp_cnt_d = '0;
            if (last_point) begin
              state_d = StDone;
            end else begin
              point_d = point_q + PtW'(1);
              snr_d   = tbl_rdata;
              state_d = StSettle;
            end
          end else begin
            smp_cnt_d = smp_cnt_q + CNT_W'(1);
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      point_q      <= '0;
      smp_cnt_q    <= '0;
      settle_cnt_q <= '0;
      num_points_q <= '0;
      spp_q        <= '0;
      snr_q        <= '0;
      // Generator stays in reset until the first clock after release.
      gen_reset_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      point_q      <= point_d;
      smp_cnt_q    <= smp_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      num_points_q <= num_points_d;
      spp_q        <= spp_d;
      snr_q        <= snr_d;
      gen_reset_q  <= (state_d == StResetGen);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      out_re_q    <= '0;
      out_im_q    <= '0;
      out_point_q <= '0;
    end else begin
      out_valid_q <= accept;
      if (accept) begin
        out_re_q    <= gen_re;
        out_im_q    <= gen_im;
        out_point_q <= point_q;
      end
    end
  end

  assign busy      = (state_q == StResetGen) || (state_q == StSettle) || (state_q == StRun);
  assign done      = (state_q == StDone);
  assign gen_ce    = (state_q == StSettle) || (state_q == StRun);
  assign gen_reset = gen_reset_q;
  assign gen_snrdB = snr_q;
  assign out_valid = out_valid_q;
  assign out_re    = out_re_q;
  assign out_im    = out_im_q;
  assign out_point = out_point_q;

endmodule
